// File: rtl/cgra_config_readback_rx.sv
`default_nettype none
// ============================================================================
//  Module   : cgra_config_readback_rx
//  Purpose  : Receiver for the serial CGRA configuration readback chain.
//             Packs the ConfigOut bitstream MSB-first into WORD_W-bit words.
//             Each completed word is XORed into a running checksum and pushed
//             into a small FIFO that has a valid/ready drain port.
//  Ports    : clock, sync_reset_n       - config clock, sync active-low reset
//             enable, bitstream_in      - bit strobe and serial data
//             word_data/valid/last      - registered FIFO head
//             word_ready                - consumer pop request
//             bit_count, done           - progress through the stream
//             overflow                  - sticky, a word was dropped
//             checksum                  - XOR of all completed words
//  Revision : 1.0  initial release
// ============================================================================
module cgra_config_readback_rx #(
  parameter int WORD_W        = 32,
  parameter int BITSTREAM_LEN = 1024,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               clock,
  input  logic                               sync_reset_n,
  input  logic                               enable,
  input  logic                               bitstream_in,
  output logic [WORD_W-1:0]                  word_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               word_last,
  output logic [$clog2(BITSTREAM_LEN+1)-1:0] bit_count,
  output logic                               done,
  output logic                               overflow,
  output logic [WORD_W-1:0]                  checksum
);

  localparam int CW = $clog2(BITSTREAM_LEN + 1);
  localparam int PW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_POS = PW'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [PW-1:0]     word_pos;   // bits already pending in the current word
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [NW-1:0]     count;
  logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;

  logic              accept;
  logic [WORD_W-1:0] shreg_next;
  logic              word_full;
  logic              final_bit;
  logic              complete;
  logic [WORD_W-1:0] new_word;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;
  logic [NW-1:0]     count_next;
  logic [AW-1:0]     rd_next;
  logic [WORD_W-1:0] head_data;
  logic              head_last;

  always_comb begin
    accept     = enable && (state != DONE);
    shreg_next = {shreg[WORD_W-2:0], bitstream_in};
    word_full  = (word_pos == LAST_POS);
    final_bit  = (bit_count == CW'(BITSTREAM_LEN - 1));
    complete   = accept && (word_full || final_bit);
    // Left-justify the pending bits; stale bits above them shift out and the
    // vacated LSBs are zero. For a full word the shift amount is zero.
    new_word   = shreg_next << (LAST_POS - word_pos);

    pop  = word_valid && word_ready;
    full = (count == NW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot that wr_ptr points at.
    push = complete && (!full || pop);
    drop = complete && full && !pop;

    count_next = count;
    if (push && !pop) count_next = count + 1'b1;
    if (pop && !push) count_next = count - 1'b1;

    rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Head output for the next cycle; bypass the memory when the word being
    // written this edge becomes the head.
    head_data = '0;
    head_last = 1'b0;
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_next)) begin
        head_data = new_word;
        head_last = final_bit;
      end else begin
        head_data = mem_data[rd_next];
        head_last = mem_last[rd_next];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= new_word;
      mem_last[wr_ptr] <= final_bit;
    end
  end

  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      word_pos   <= '0;
      bit_count  <= '0;
      checksum   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        shreg     <= shreg_next;
        bit_count <= bit_count + 1'b1;
        word_pos  <= word_full ? '0 : word_pos + 1'b1;
        if (final_bit) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state <= SHIFT;
        end
      end
      if (complete) checksum <= checksum ^ new_word;
      if (drop)     overflow <= 1'b1;
      if (push)     wr_ptr   <= wr_ptr + 1'b1;
      rd_ptr     <= rd_next;
      count      <= count_next;
      word_data  <= head_data;
      word_last  <= head_last;
      word_valid <= (count_next != '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cgra_config_readback_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cgra_config_readback_rx
//  Purpose  : Self-checking bench for cgra_config_readback_rx with a
//             queue-based reference model of the packer, checksum and FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cgra_config_readback_rx;

  localparam int WORD_W = 8;
  localparam int LEN    = 20;
  localparam int DEPTH  = 2;

  logic         clock;
  logic         sync_reset_n;
  logic         enable;
  logic         bitstream_in;
  logic [7:0]   word_data;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic [4:0]   bit_count;
  logic         done;
  logic         overflow;
  logic [7:0]   checksum;

  cgra_config_readback_rx #(
    .WORD_W(WORD_W), .BITSTREAM_LEN(LEN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .sync_reset_n(sync_reset_n), .enable(enable),
    .bitstream_in(bitstream_in), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .word_last(word_last), .bit_count(bit_count),
    .done(done), .overflow(overflow), .checksum(checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bits counted, pending partial word, FIFO as a queue.
  typedef struct { int data; bit last; } entry_t;
  entry_t m_q[$];
  int m_bits, m_pend, m_pk, m_chk;
  bit m_ovf, m_done;

  task automatic model_reset();
    m_q.delete();
    m_bits = 0; m_pend = 0; m_pk = 0; m_chk = 0;
    m_ovf = 0; m_done = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, 32'(word_valid), 32'(m_q.size() > 0));
    check_eq({tag, ".data"}, 32'(word_data), (m_q.size() > 0) ? 32'(m_q[0].data) : 32'd0);
    check_eq({tag, ".last"}, 32'(word_last), (m_q.size() > 0) ? 32'(m_q[0].last) : 32'd0);
    check_eq({tag, ".bit_count"}, 32'(bit_count), 32'(m_bits));
    check_eq({tag, ".done"}, 32'(done), 32'(m_done));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".checksum"}, 32'(checksum), 32'(m_chk));
  endtask

  // One clock edge: drive inputs, advance the model, compare just after.
  task automatic step(input logic en, input logic b, input logic rdy, input logic rn,
                      input string tag);
    bit pop, was_full, cmp;
    int word;
    enable = en; bitstream_in = b; word_ready = rdy; sync_reset_n = rn;
    @(posedge clock);
    if (!rn) begin
      model_reset();
    end else begin
      pop = (m_q.size() > 0) && rdy;
      was_full = (m_q.size() >= DEPTH);
      cmp = 0; word = 0;
      if (en && !m_done) begin
        m_pend = (m_pend << 1) | int'(b);
        m_pk++;
        m_bits++;
        if (m_pk == WORD_W || m_bits == LEN) begin
          word = (m_pend << (WORD_W - m_pk)) & 8'hFF;
          cmp = 1;
          m_pend = 0; m_pk = 0;
        end
        if (m_bits == LEN) m_done = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (cmp) begin
        m_chk ^= word;
        if (was_full && !pop) m_ovf = 1;
        else m_q.push_back('{data: word, last: (m_bits == LEN)});
      end
    end
    #1;
    check_all(tag);
  endtask

  logic [19:0] stream;
  initial stream = {8'hA5, 8'h3C, 4'hF};

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, "reset");
  endtask

  initial begin
    enable = 0; bitstream_in = 0; word_ready = 0; sync_reset_n = 0;
    model_reset();
    @(negedge clock);

    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "idle");
    check_eq("t1.bit_count", 32'(bit_count), 32'd0);

    // 2: stream with consumer always ready
    do_reset();
    for (int i = 19; i >= 0; i--) step(1'b1, stream[i], 1'b1, 1'b1, "t2");
    check_eq("t2.last_word", 32'(word_data), 32'hF0);
    check_eq("t2.last_flag", 32'(word_last), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "t2.drain");
    check_eq("t2.checksum", 32'(checksum), 32'h69);
    check_eq("t2.done", 32'(done), 32'd1);

    // 3: consumer stalled, third word dropped, then drain
    do_reset();
    for (int i = 19; i >= 0; i--) step(1'b1, stream[i], 1'b0, 1'b1, "t3");
    check_eq("t3.overflow", 32'(overflow), 32'd1);
    check_eq("t3.head", 32'(word_data), 32'hA5);
    check_eq("t3.checksum", 32'(checksum), 32'h69);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "t3.drain");

    // 4: enable toggled every cycle
    do_reset();
    for (int i = 19; i >= 0; i--) begin
      step(1'b1, stream[i], 1'b1, 1'b1, "t4.on");
      step(1'b0, ~stream[i], 1'b1, 1'b1, "t4.off");
    end
    check_eq("t4.done", 32'(done), 32'd1);
    check_eq("t4.checksum", 32'(checksum), 32'h69);

    // 5: reset mid-stream then resend
    do_reset();
    for (int i = 19; i >= 8; i--) step(1'b1, stream[i], 1'b0, 1'b1, "t5.pre");
    do_reset();
    check_eq("t5.bit_count", 32'(bit_count), 32'd0);
    for (int i = 19; i >= 0; i--) step(1'b1, stream[i], 1'b1, 1'b1, "t5");
    check_eq("t5.checksum", 32'(checksum), 32'h69);

    // 6: FIFO full with push+pop on the same edge, then bits after done
    do_reset();
    for (int i = 19; i >= 1; i--) step(1'b1, stream[i], 1'b0, 1'b1, "t6.fill");
    step(1'b1, stream[0], 1'b1, 1'b1, "t6.pushpop");
    check_eq("t6.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, "t6.extra");
    check_eq("t6.bit_count", 32'(bit_count), 32'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "t6.drain");

    // Randomized phase
    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int c = 0; c < 70; c++) begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 99) != 0), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
